// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear sequencer states.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Widest data word the zero helper can produce.
  localparam int RF_MAX_W = 64;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int RF_DEPTH(input int addr_w);
    return 1 << addr_w;
  endfunction

  // All-zero word, clipped to the low data_w bits.
  function automatic logic [RF_MAX_W-1:0] RF_ZERO(input int data_w);
    logic [RF_MAX_W-1:0] mask;
    mask = ~({RF_MAX_W{1'b1}} << data_w);
    return {RF_MAX_W{1'b0}} & mask;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: zero/busy gating, write-to-read forwarding with
// fixed priority (highest write port wins), optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int SYNC_RD  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic                     busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam logic [DATA_W-1:0] ZERO = DATA_W'(RF_ZERO(DATA_W));

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Select read value: gated zero, else forwarded write, else storage.
  // wr_en only carries writes that will really land, so dropped writes
  // never forward.
  always_comb begin
    rdata_d = ZERO;
    if (re && !busy && !((ZERO_REG != 0) && (raddr == '0))) begin
      rdata_d = mem_rdata;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr)) begin
          rdata_d = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered read path; unused (and optimised away) for combinational reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= ZERO;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = (SYNC_RD != 0) ? rdata_q : rdata_d;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage array, write decode and the clear
// sequencer that zeroes every entry after reset or on clr_req.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int SYNC_RD  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int                DEPTH    = RF_DEPTH(ADDR_W);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_wr;
  logic [NUM_WR-1:0] wr_en;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign busy = (state_q == RF_CLEAR) | rst;

  // Clear sequencer: walk ptr over every entry, pulse clr_done on the last one.
  // clr_req in CLEAR is ignored so the walk never restarts on a request.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_wr   = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_wr = !rst;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          clr_done = !rst;
          state_d  = RF_IDLE;
          ptr_d    = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Sequencer state; reset restarts the walk from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Effective write enables: only in IDLE, not in the clr_req cycle,
  // and never to entry 0 when it is hard-wired to zero.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_en[j] = we[j] && (state_q == RF_IDLE) && !clr_req && !rst &&
                 !((ZERO_REG != 0) && (waddr[j*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Storage update; later write ports override earlier ones on an address clash.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          mem_q[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .SYNC_RD (SYNC_RD)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .re       (re[i]),
      .raddr    (raddr[i*ADDR_W +: ADDR_W]),
      .busy     (busy),
      .wr_en    (wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .mem_rdata(mem_q[raddr[i*ADDR_W +: ADDR_W]]),
      .rdata    (rdata[i*DATA_W +: DATA_W])
    );
  end

endmodule
